// File: rtl/interleaver_pkg.sv
// Shared types and width helpers for the junction interleaver address generator.
// Included by the slot map, the output-stream interface users and the top level.
package interleaver_pkg;

    typedef enum logic {
        MODE_INTERLEAVE = 1'b0,
        MODE_IDENTITY   = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int calc_ws(input int p, input int z);
        return $clog2(p / z);
    endfunction

    function automatic int calc_wc(input int fo, input int p, input int z);
        return $clog2(fo * p / z);
    endfunction

    function automatic int calc_wm(input int p);
        return $clog2(p);
    endfunction

    function automatic int calc_wa(input int fo, input int z);
        return $clog2(fo * z);
    endfunction

    function automatic int calc_wb(input int nj);
        return (nj > 1) ? $clog2(nj) : 1;
    endfunction

endpackage

// File: rtl/interleaver_agen_if.sv
// Valid/ready beat stream carrying Z activation-memory indices per cycle.
// The master modport is the generator side; the slave modport is the consumer side.
interface interleaver_agen_if #(
    parameter int WM = 5,
    parameter int Z  = 8,
    parameter int WC = 3
) ();
    logic              out_valid;
    logic              out_ready;
    logic [WM*Z-1:0]   out_index;
    logic [WC-1:0]     out_cycle;
    logic              out_last;

    modport master (
        output out_valid,
        output out_index,
        output out_cycle,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_cycle,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/interleaver_slot.sv
// Combinational map from (cycle, slot J, this slot's sweep-start column) to one index.
// The slot index is fixed, so i mod Z is J and i div Z is just the low WS bits of the cycle.
module interleaver_slot
    import interleaver_pkg::*;
#(
    parameter int FO = 2,
    parameter int P  = 32,
    parameter int Z  = 8,
    parameter int J  = 0,
    localparam int WS = calc_ws(P, Z),
    localparam int WC = calc_wc(FO, P, Z),
    localparam int WM = calc_wm(P)
) (
    input  logic [WC-1:0]    cycle,
    input  logic [FO*WS-1:0] starts,
    input  mode_e            mode,
    output logic [WM-1:0]    index
);
    localparam int WZ = WM - WS;
    localparam logic [WZ-1:0] SLOT = WZ'(J);

    logic [WS-1:0] row_off;
    logic [WS-1:0] start_v;
    logic [WS-1:0] rot;
    int            sweep;

    // The sweep-start add wraps naturally in WS bits, which keeps each sweep a permutation.
    always_comb begin
        row_off = cycle[WS-1:0];
        sweep   = int'(cycle >> WS);
        start_v = starts[sweep*WS +: WS];
        rot     = start_v + row_off;
        if (mode == MODE_IDENTITY) begin
            index = {row_off, SLOT};
        end else begin
            index = {rot, SLOT};
        end
    end

endmodule

// File: rtl/interleaver_agen.sv
// Runtime-configurable interleaver address generator: loadable sweep-start tables,
// a two-state pass FSM and a valid/ready output register streaming Z indices per beat.
module interleaver_agen
    import interleaver_pkg::*;
#(
    parameter int FO = 2,
    parameter int P  = 32,
    parameter int Z  = 8,
    parameter int NJ = 1,
    localparam int WS   = calc_ws(P, Z),
    localparam int WC   = calc_wc(FO, P, Z),
    localparam int WM   = calc_wm(P),
    localparam int WA   = calc_wa(FO, Z),
    localparam int WB   = calc_wb(NJ),
    localparam int NCYC = FO * P / Z
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [WB-1:0] cfg_bank,
    input  logic [WA-1:0] cfg_addr,
    input  logic [WS-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          start,
    input  logic [WB-1:0] junc,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    interleaver_agen_if.master ob
);

    state_e                               state_q, state_d;
    logic [NJ-1:0][FO*Z-1:0][WS-1:0]      table_q, table_d;
    logic [WB-1:0]                        junc_q, junc_d;
    mode_e                                mode_q, mode_d;
    logic                                 valid_q, valid_d;
    logic                                 last_q, last_d;
    logic                                 done_q, done_d;
    logic                                 err_q, err_d;
    logic [WC-1:0]                        cycle_q, cycle_d;
    logic [WM*Z-1:0]                      index_q, index_d;

    logic          hs, load_first, load_next, finish;
    logic          bank_ok;
    logic [WC-1:0] ld_cycle;
    logic [WB-1:0] ld_bank;
    mode_e         ld_mode;
    logic [FO*WS-1:0] cols [Z];
    logic [WM-1:0]    slot_index [Z];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            table_q <= '0;
            junc_q  <= '0;
            mode_q  <= MODE_INTERLEAVE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cycle_q <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            junc_q  <= junc_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cycle_q <= cycle_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (hs && last_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_RUN);
        hs         = valid_q && ob.out_ready;
        load_first = (state_q == ST_IDLE) && start;
        load_next  = (state_q == ST_RUN) && hs && !last_q;
        finish     = (state_q == ST_RUN) && hs && last_q;
    end

    // The beat being loaded reads the table of the bank it will run on, captured or incoming.
    always_comb begin
        ld_cycle = load_first ? '0 : cycle_q + WC'(1);
        ld_bank  = load_first ? junc : junc_q;
        ld_mode  = load_first ? mode_e'(mode) : mode_q;
        bank_ok  = int'(ld_bank) < NJ;
        cols     = '{default: '0};
        for (int j = 0; j < Z; j++) begin
            for (int s = 0; s < FO; s++) begin
                cols[j][s*WS +: WS] = bank_ok ? table_q[ld_bank][s*Z + j] : '0;
            end
        end
    end

    for (genvar g = 0; g < Z; g++) begin : g_slot
        interleaver_slot #(.FO(FO), .P(P), .Z(Z), .J(g)) u_slot (
            .cycle  (ld_cycle),
            .starts (cols[g]),
            .mode   (ld_mode),
            .index  (slot_index[g])
        );
    end

    always_comb begin
        table_d = table_q;
        err_d   = err_q;
        if (cfg_we) begin
            if (busy && (cfg_bank == junc_q)) begin
                err_d = 1'b1;
            end else if ((int'(cfg_bank) < NJ) && (int'(cfg_addr) < FO*Z)) begin
                table_d[cfg_bank][cfg_addr] = cfg_data;
            end
        end
    end

    always_comb begin
        junc_d  = junc_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        last_d  = last_q;
        cycle_d = cycle_q;
        index_d = index_q;
        done_d  = finish;
        if (load_first) begin
            junc_d = junc;
            mode_d = mode_e'(mode);
        end
        if (load_first || load_next) begin
            valid_d = 1'b1;
            cycle_d = ld_cycle;
            last_d  = (ld_cycle == WC'(NCYC - 1));
            for (int j = 0; j < Z; j++) begin
                index_d[j*WM +: WM] = slot_index[j];
            end
        end else if (finish) begin
            valid_d = 1'b0;
        end
    end

    assign ob.out_valid = valid_q;
    assign ob.out_index = index_q;
    assign ob.out_cycle = cycle_q;
    assign ob.out_last  = last_q;
    assign cfg_err      = err_q;
    assign done         = done_q;

endmodule

// File: tb/tb_interleaver_agen.sv
// Directed bench for interleaver_agen with P=32, Z=8, FO=2, NJ=2 (eight beats per pass).
// Expected indices come from a small table model evaluated with the w/i/s/t formulas.
module tb_interleaver_agen;
    import interleaver_pkg::*;

    localparam int FO = 2, P = 32, Z = 8, NJ = 2;
    localparam int WS = 2, WC = 3, WM = 5, WA = 4, WB = 1, NCYC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [WB-1:0] cfg_bank = '0;
    logic [WA-1:0] cfg_addr = '0;
    logic [WS-1:0] cfg_data = '0;
    logic          cfg_err;
    logic          start = 1'b0;
    logic [WB-1:0] junc = '0;
    logic          mode = 1'b0;
    logic          busy;
    logic          done;

    interleaver_agen_if #(.WM(WM), .Z(Z), .WC(WC)) ob_if ();

    interleaver_agen #(.FO(FO), .P(P), .Z(Z), .NJ(NJ)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_bank (cfg_bank),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .start    (start),
        .junc     (junc),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .ob       (ob_if)
    );

    always #5 clk = ~clk;

    int cmp_count = 0;
    int err_count = 0;
    int mtab [NJ][FO*Z];
    int beats [NCYC][Z];

    task automatic checkOutput(input string tag, input int obs, input int exp);
        cmp_count++;
        if (obs != exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int modelIndex(input int b, input int md, input int c, input int j);
        int w, i, s, t;
        w = c * Z + j;
        i = w % P;
        s = c / (P / Z);
        if (md != 0) return i;
        t = (mtab[b][s*Z + i%Z] + i/Z) % (P / Z);
        return t * Z + i % Z;
    endfunction

    function automatic int slotOf(input int j);
        return int'(ob_if.out_index[j*WM +: WM]);
    endfunction

    task automatic applyStimulus(input int bank, input int md);
        start = 1'b1;
        junc  = WB'(bank);
        mode  = md[0];
        step();
        start = 1'b0;
    endtask

    task automatic cfgWrite(input int bank, input int addr, input int data, input bit lands);
        cfg_we   = 1'b1;
        cfg_bank = WB'(bank);
        cfg_addr = WA'(addr);
        cfg_data = WS'(data);
        step();
        cfg_we = 1'b0;
        if (lands) mtab[bank][addr] = data;
    endtask

    task automatic runPass(input string tag, input int bank, input int md,
                           input int stall_beat, input int stall_len);
        int c = 0;
        int waited = 0;
        int cycles = 0;
        applyStimulus(bank, md);
        checkOutput({tag, "_busy"}, busy, 1);
        while (c < NCYC && cycles < 50) begin
            checkOutput($sformatf("%s_valid_c%0d", tag, c), ob_if.out_valid, 1);
            checkOutput($sformatf("%s_cycle_c%0d", tag, c), ob_if.out_cycle, c);
            checkOutput($sformatf("%s_last_c%0d", tag, c), ob_if.out_last, (c == NCYC-1) ? 1 : 0);
            checkOutput($sformatf("%s_nodone_c%0d", tag, c), done, 0);
            for (int j = 0; j < Z; j++) begin
                checkOutput($sformatf("%s_idx_c%0d_s%0d", tag, c, j), slotOf(j), modelIndex(bank, md, c, j));
                beats[c][j] = slotOf(j);
            end
            if (c == stall_beat && waited < stall_len) begin
                ob_if.out_ready = 1'b0;
                waited++;
            end else begin
                ob_if.out_ready = 1'b1;
            end
            step();
            if (ob_if.out_ready) c++;
            cycles++;
        end
        ob_if.out_ready = 1'b1;
        checkOutput({tag, "_cycles"}, cycles, NCYC + stall_len);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_idle"}, busy, 0);
        checkOutput({tag, "_valid_end"}, ob_if.out_valid, 0);
        step();
        checkOutput({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic checkPerm(input string tag);
        for (int s = 0; s < FO; s++) begin
            bit seen [P];
            int n = 0;
            seen = '{default: 1'b0};
            for (int c = s * (P/Z); c < (s+1) * (P/Z); c++) begin
                for (int j = 0; j < Z; j++) begin
                    if (!seen[beats[c][j]]) n++;
                    seen[beats[c][j]] = 1'b1;
                end
            end
            checkOutput($sformatf("%s_perm_sweep%0d", tag, s), n, P);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        ob_if.out_ready = 1'b1;
        for (int b = 0; b < NJ; b++)
            for (int a = 0; a < FO*Z; a++) mtab[b][a] = 0;

        step();
        step();
        checkOutput("rst_valid", ob_if.out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", cfg_err, 0);
        checkOutput("rst_cycle", ob_if.out_cycle, 0);
        checkOutput("rst_last", ob_if.out_last, 0);
        checkOutput("rst_index_zero", (ob_if.out_index == '0) ? 1 : 0, 1);
        reset = 1'b0;
        step();

        runPass("base", 0, 0, -1, 0);
        checkOutput("base_b0s0", beats[0][0], 0);
        checkOutput("base_b0s7", beats[0][7], 7);
        checkOutput("base_b1s0", beats[1][0], 8);
        checkOutput("base_b4s3", beats[4][3], 3);
        checkOutput("base_b7s7", beats[7][7], 31);

        cfgWrite(0, 0, 3, 1'b1);
        runPass("wr3", 0, 0, -1, 0);
        checkOutput("wr3_b0s0", beats[0][0], 24);
        checkOutput("wr3_b1s0", beats[1][0], 0);
        checkOutput("wr3_b4s0", beats[4][0], 0);
        runPass("bank1", 1, 0, -1, 0);
        checkOutput("bank1_b0s0", beats[0][0], 0);

        for (int a = 0; a < FO*Z; a++) cfgWrite(0, a, int'($urandom_range(0, 3)), 1'b1);
        runPass("rand", 0, 0, -1, 0);
        checkPerm("rand");

        runPass("stall", 0, 0, 2, 3);
        checkPerm("stall");

        applyStimulus(0, 0);
        cfgWrite(1, 3, 1, 1'b1);
        checkOutput("run_wr_other_err", cfg_err, 0);
        cfgWrite(0, 5, (mtab[0][5] + 1) % 4, 1'b0);
        checkOutput("run_wr_same_err", cfg_err, 1);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        checkOutput("run_wr_done", done, 1);
        step();
        runPass("chk0", 0, 0, -1, 0);
        runPass("chk1", 1, 0, -1, 0);
        checkOutput("chk1_b0s3", beats[0][3], 11);
        checkOutput("err_sticky", cfg_err, 1);

        applyStimulus(0, 0);
        for (int k = 0; k < 5; k++) step();
        checkOutput("abort_cycle", ob_if.out_cycle, 5);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_valid", ob_if.out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cycle_rst", ob_if.out_cycle, 0);
        checkOutput("abort_last", ob_if.out_last, 0);
        checkOutput("abort_err", cfg_err, 0);
        checkOutput("abort_index_zero", (ob_if.out_index == '0) ? 1 : 0, 1);
        for (int b = 0; b < NJ; b++)
            for (int a = 0; a < FO*Z; a++) mtab[b][a] = 0;
        step();
        checkOutput("abort_nodone0", done, 0);
        reset = 1'b0;
        step();
        checkOutput("abort_nodone1", done, 0);
        checkOutput("abort_idle", busy, 0);

        runPass("ident", 1, 1, -1, 0);
        checkOutput("ident_b5s2", beats[5][2], 10);
        checkOutput("ident_b3s7", beats[3][7], 31);
        runPass("post", 0, 0, -1, 0);
        checkOutput("post_b0s0", beats[0][0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
